// File: rtl/la_rle_encoder.sv
// Run-length encoder between the LA input sampler and the SRAM write port.
// Define LA_RLE_MASK_EN to let CMP_MASK select which channels take part in the run compare.
module la_rle_encoder #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLK_EN,
    input  logic              RLE_EN,
    input  logic              FLUSH,
    input  logic [DATA_W-1:0] CMP_MASK,
    input  logic [DATA_W-1:0] LA_IN_DATA,
    output logic [DATA_W-1:0] LA_OUT_DATA,
    output logic [CNT_W-1:0]  LA_RLE_OUT_DATA,
    output logic              LA_SRAM_ADDR_CNT_EN,
    output logic              BUSY
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   cur_data, cur_data_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [DATA_W-1:0]   eff_mask;
    logic                run_break;
    logic                emit;

`ifdef LA_RLE_MASK_EN
    assign eff_mask = CMP_MASK;
`else
    // Port kept so both builds share one pinout; every channel is compared.
    logic unused_cmp_mask;
    assign unused_cmp_mask = ^CMP_MASK;
    assign eff_mask        = '1;
`endif

    assign run_break = (((LA_IN_DATA ^ cur_data) & eff_mask) != '0)
                     || !RLE_EN
                     || (cnt == CNT_MAX);

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt    = state;
        cur_data_nxt = cur_data;
        cnt_nxt      = cnt;
        emit         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (CLK_EN) begin
                    cur_data_nxt = LA_IN_DATA;
                    cnt_nxt      = '0;
                    state_nxt    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (FLUSH) begin
                    emit      = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (CLK_EN) begin
                    if (run_break) begin
                        emit         = 1'b1;
                        cur_data_nxt = LA_IN_DATA;
                        cnt_nxt      = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state               <= ST_IDLE;
            cur_data            <= '0;
            cnt                 <= '0;
            LA_OUT_DATA         <= '0;
            LA_RLE_OUT_DATA     <= '0;
            LA_SRAM_ADDR_CNT_EN <= 1'b0;
        end else begin
            state               <= state_nxt;
            cur_data            <= cur_data_nxt;
            cnt                 <= cnt_nxt;
            LA_SRAM_ADDR_CNT_EN <= emit;
            if (emit) begin
                LA_OUT_DATA     <= cur_data;
                LA_RLE_OUT_DATA <= cnt;
            end
        end
    end

    assign BUSY = (state == ST_RUN);

endmodule

// File: tb/tb_la_rle_encoder.sv
// Self-checking bench for la_rle_encoder: directed scenarios plus randomized traffic
// against a run-list reference model. Honours LA_RLE_MASK_EN like the design.
module tb_la_rle_encoder;

    localparam int DATA_W  = 8;
    localparam int CNT_W   = 8;
    localparam int RUN_CAP = 1 << CNT_W;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              CLK_EN;
    logic              RLE_EN;
    logic              FLUSH;
    logic [DATA_W-1:0] CMP_MASK;
    logic [DATA_W-1:0] LA_IN_DATA;
    logic [DATA_W-1:0] LA_OUT_DATA;
    logic [CNT_W-1:0]  LA_RLE_OUT_DATA;
    logic              LA_SRAM_ADDR_CNT_EN;
    logic              BUSY;

    la_rle_encoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .CLK                (CLK),
        .RST_N              (RST_N),
        .CLK_EN             (CLK_EN),
        .RLE_EN             (RLE_EN),
        .FLUSH              (FLUSH),
        .CMP_MASK           (CMP_MASK),
        .LA_IN_DATA         (LA_IN_DATA),
        .LA_OUT_DATA        (LA_OUT_DATA),
        .LA_RLE_OUT_DATA    (LA_RLE_OUT_DATA),
        .LA_SRAM_ADDR_CNT_EN(LA_SRAM_ADDR_CNT_EN),
        .BUSY               (BUSY)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a pending run is its first sample plus the number of samples in it.
    bit                m_pend;
    logic [DATA_W-1:0] m_first;
    int                m_len;
    logic [DATA_W-1:0] m_last_data;
    logic [CNT_W-1:0]  m_last_cnt;
    bit                m_strobe;
    int                m_accepted;
    int                dut_sample_sum;

    logic              cur_rle;
    logic [DATA_W-1:0] cur_msk;
    logic [15:0]       got_w[$];
    logic [15:0]       exp_w[$];

    task automatic model_reset();
        m_pend         = 0;
        m_first        = '0;
        m_len          = 0;
        m_last_data    = '0;
        m_last_cnt     = '0;
        m_strobe       = 0;
        m_accepted     = 0;
        dut_sample_sum = 0;
    endtask

    task automatic model_emit();
        m_strobe    = 1;
        m_last_data = m_first;
        m_last_cnt  = CNT_W'(m_len - 1);
    endtask

    task automatic model_step(input bit ce, input bit fl, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] m;
`ifdef LA_RLE_MASK_EN
        m = cur_msk;
`else
        m = '1;
`endif
        m_strobe = 0;
        if (!m_pend) begin
            if (ce) begin
                m_pend  = 1;
                m_first = d;
                m_len   = 1;
                m_accepted++;
            end
        end else if (fl) begin
            model_emit();
            m_pend = 0;
        end else if (ce) begin
            m_accepted++;
            if (((d ^ m_first) & m) != 0 || !cur_rle || m_len == RUN_CAP) begin
                model_emit();
                m_first = d;
                m_len   = 1;
            end else begin
                m_len++;
            end
        end
    endtask

    // One clock: drive inputs, advance the model, then sample outputs 1 ns after the edge.
    task automatic step(input bit ce, input bit fl, input logic [DATA_W-1:0] d);
        CLK_EN     = ce;
        FLUSH      = fl;
        LA_IN_DATA = d;
        RLE_EN     = cur_rle;
        CMP_MASK   = cur_msk;
        model_step(ce, fl, d);
        @(posedge CLK);
        #1;
        check("strobe", 32'(LA_SRAM_ADDR_CNT_EN), 32'(m_strobe));
        check("busy", 32'(BUSY), 32'(m_pend));
        check("out_data", 32'(LA_OUT_DATA), 32'(m_last_data));
        check("rle_cnt", 32'(LA_RLE_OUT_DATA), 32'(m_last_cnt));
        if (LA_SRAM_ADDR_CNT_EN) begin
            got_w.push_back({LA_OUT_DATA, LA_RLE_OUT_DATA});
            dut_sample_sum += int'(LA_RLE_OUT_DATA) + 1;
        end
    endtask

    task automatic check_words(input string tag);
        check({tag, "_nwords"}, 32'(got_w.size()), 32'(exp_w.size()));
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
            check({tag, "_word"}, 32'(got_w[i]), 32'(exp_w[i]));
        got_w.delete();
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
    endtask

    logic [DATA_W-1:0] rd;
    bit                rce, rfl;

    initial begin
        CLK_EN     = 1'b0;
        RLE_EN     = 1'b1;
        FLUSH      = 1'b0;
        CMP_MASK   = '1;
        LA_IN_DATA = '0;
        cur_rle    = 1'b1;
        cur_msk    = '1;
        model_reset();
        RST_N = 1'b0;
        #12;
        check("rst_out_data", 32'(LA_OUT_DATA), 32'h0);
        check("rst_rle_cnt", 32'(LA_RLE_OUT_DATA), 32'h0);
        check("rst_strobe", 32'(LA_SRAM_ADDR_CNT_EN), 32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);
        apply_reset();

        // Two runs closed by a flush.
        got_w.delete();
        repeat (5) step(1, 0, 8'h11);
        repeat (3) step(1, 0, 8'h22);
        step(0, 1, 8'h00);
        check("t1_busy_after_flush", 32'(BUSY), 32'h0);
        exp_w = '{16'h1104, 16'h2202};
        check_words("t1");

        // Compression off: one word per sample.
        cur_rle = 1'b0;
        step(1, 0, 8'hA0);
        step(1, 0, 8'hA0);
        step(1, 0, 8'hA1);
        step(0, 1, 8'h00);
        exp_w = '{16'hA000, 16'hA000, 16'hA100};
        check_words("t2");
        cur_rle = 1'b1;

        // Counter saturation.
        repeat (300) step(1, 0, 8'h55);
        step(0, 1, 8'h00);
        exp_w = '{16'h55FF, 16'h552B};
        check_words("t3");

        // Stall in the middle of a run.
        repeat (2) step(1, 0, 8'h33);
        repeat (10) step(0, 0, 8'h33);
        repeat (2) step(1, 0, 8'h33);
        step(1, 0, 8'h44);
        step(0, 1, 8'h00);
        exp_w = '{16'h3303, 16'h4400};
        check_words("t4");

        // Asynchronous reset mid-run clears outputs at once.
        repeat (6) step(1, 0, 8'h77);
        RST_N = 1'b0;
        #1;
        check("t5_out_data", 32'(LA_OUT_DATA), 32'h0);
        check("t5_rle_cnt", 32'(LA_RLE_OUT_DATA), 32'h0);
        check("t5_strobe", 32'(LA_SRAM_ADDR_CNT_EN), 32'h0);
        check("t5_busy", 32'(BUSY), 32'h0);
        @(posedge CLK);
        #1;
        check("t5_strobe_in_rst", 32'(LA_SRAM_ADDR_CNT_EN), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        step(1, 0, 8'h01);
        step(0, 1, 8'h00);
        exp_w = '{16'h0100};
        check_words("t5");

        // Channel compare mask.
        cur_msk = 8'h0F;
        step(1, 0, 8'h10);
        step(1, 0, 8'h20);
        step(1, 0, 8'h30);
        step(1, 0, 8'h31);
        step(0, 1, 8'h00);
`ifdef LA_RLE_MASK_EN
        exp_w = '{16'h1002, 16'h3100};
`else
        exp_w = '{16'h1000, 16'h2000, 16'h3000, 16'h3100};
`endif
        check_words("t6");

        // Randomized traffic; the model checks every cycle.
        rd = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) cur_msk = DATA_W'($urandom);
            if (i % 50 == 0) cur_rle = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 5) == 0) rd = DATA_W'($urandom_range(0, 255));
            rce = ($urandom_range(0, 3) != 0);
            rfl = ($urandom_range(0, 49) == 0);
            step(rce, rfl, rd);
        end
        step(0, 1, 8'h00);
        check("sample_sum", 32'(dut_sample_sum), 32'(m_accepted));
        check("final_busy", 32'(BUSY), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
